// File: rtl/xip_line_cache.sv
// Direct-mapped read-only line cache in front of the QSPI XIP flash controller.
// Optional build macro XIP_CACHE_INVAL_EN adds an 'inval' input that clears all valid bits.
module xip_line_cache #(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned LINE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef XIP_CACHE_INVAL_EN
  input  logic                   inval,
`endif
  input  logic                   req_valid,
  input  logic [23:0]            req_addr,
  output logic                   req_ready,
  output logic                   rvalid,
  output logic [31:0]            rdata,
  output logic                   fl_rd,
  output logic [23:0]            fl_addr,
  input  logic                   fl_done,
  input  logic [LINE_SIZE*8-1:0] fl_line
);

  localparam int unsigned OFF   = $clog2(LINE_SIZE);
  localparam int unsigned IDX   = $clog2(NUM_LINES);
  localparam int unsigned TAG   = 24 - OFF - IDX;
  localparam int unsigned LW    = LINE_SIZE * 8;
  localparam int unsigned WORDS = LINE_SIZE / 4;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT} state_e;

  state_e               state_q;
  logic [23:2]          addr_q;
  logic                 req_ready_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;
  logic                 fl_rd_q;
  logic [23:0]          fl_addr_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG-1:0]       tag_q  [NUM_LINES];
  logic [LW-1:0]        data_q [NUM_LINES];

  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;
  logic [LW-1:0]  hit_line;
  logic [31:0]    hit_words  [WORDS];
  logic [31:0]    fill_words [WORDS];
  logic [31:0]    hit_word;
  logic [31:0]    fill_word;
  logic           hit;
  logic           fill_we;
  logic           ret_idle;
  logic           inval_now;
  logic           addr_lsb_unused;

  assign addr_lsb_unused = ^req_addr[1:0];

  assign idx      = addr_q[OFF+IDX-1:OFF];
  assign tag      = addr_q[23:OFF+IDX];
  assign hit_line = data_q[idx];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign fill_we  = (state_q == FILL_WAIT) && fl_done;
  assign ret_idle = ((state_q == LOOKUP) && hit) || fill_we;

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    assign hit_words[w]  = hit_line[w*32 +: 32];
    assign fill_words[w] = fl_line[w*32 +: 32];
  end

  if (OFF > 2) begin : g_wsel
    logic [OFF-3:0] wsel;
    assign wsel      = addr_q[OFF-1:2];
    assign hit_word  = hit_words[wsel];
    assign fill_word = fill_words[wsel];
  end else begin : g_nowsel
    assign hit_word  = hit_words[0];
    assign fill_word = fill_words[0];
  end

`ifdef XIP_CACHE_INVAL_EN
  logic inval_pend_q;

  // An invalidate seen while busy is held until the transaction returns to IDLE,
  // so the line being filled is cleared along with the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inval_pend_q <= 1'b0;
    end else if (state_q == IDLE || ret_idle) begin
      inval_pend_q <= 1'b0;
    end else if (inval) begin
      inval_pend_q <= 1'b1;
    end
  end

  assign inval_now = inval | inval_pend_q;
`else
  assign inval_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      req_ready_q <= 1'b1;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      fl_rd_q     <= 1'b0;
      fl_addr_q   <= '0;
      valid_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      fl_rd_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (inval_now) valid_q <= '0;
          if (req_valid) begin
            addr_q      <= req_addr[23:2];
            req_ready_q <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            rvalid_q    <= 1'b1;
            rdata_q     <= hit_word;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
            if (inval_now) valid_q <= '0;
          end else begin
            fl_rd_q   <= 1'b1;
            fl_addr_q <= {addr_q[23:OFF], {OFF{1'b0}}};
            state_q   <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          state_q <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (fl_done) begin
            rvalid_q    <= 1'b1;
            rdata_q     <= fill_word;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
            if (inval_now) valid_q <= '0;
            else           valid_q[idx] <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[idx] <= fl_line;
      tag_q[idx]  <= tag;
    end
  end

  assign req_ready = req_ready_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign fl_rd     = fl_rd_q;
  assign fl_addr   = fl_addr_q;

endmodule
